// File: rtl/elevator_car_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_car_ctrl_pkg
//  Purpose  : Shared definitions for the elevator car-motion controller:
//             state encodings and travel-direction codes.
//  Revision : 1.0 - initial release
// ============================================================================
package elevator_car_ctrl_pkg;

    // Controller states (2-bit encoding)
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_MOVE_UP   = 2'd1;
    localparam logic [1:0] c_ST_MOVE_DOWN = 2'd2;
    localparam logic [1:0] c_ST_DOOR      = 2'd3;

    // Remembered travel direction, used for SCAN-style preference
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/elevator_car_ctrl_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_car_ctrl_tick_timer
//  Purpose  : Up-counter with synchronous clear and enable, and a terminal-
//             count compare. One instance is shared by the move and door
//             phases; the owner supplies the terminal value for each phase.
//  Ports    : clk10  - system tick clock
//             rst    - synchronous reset, active low
//             clear  - force count to zero (wins over enable)
//             enable - advance count by one
//             term   - terminal count to compare against
//             done   - count currently equals term
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk10,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk10) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign done = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_car_ctrl
//  Purpose  : Car-motion controller. Serves the latched call-lamp vector:
//             moves one floor per TRAVEL_TICKS, holds the door open for
//             DOOR_TICKS, and pulses clr[] so the lamp latch drops the
//             served floor. Direction preference follows SCAN.
//  Ports    : clk10     - 0.1 s system tick clock
//             rst       - synchronous reset, active low
//             light     - pending calls (one bit per floor, bit0 = ground)
//             floor     - current car position, one-hot
//             mv_up     - car travelling up
//             mv_down   - car travelling down
//             door_open - door open
//             clr       - one-cycle pulse clearing the call at that floor
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl
    import elevator_car_ctrl_pkg::*;
#(
    parameter int N_FLOORS     = 3,
    parameter int TRAVEL_TICKS = 20,
    parameter int DOOR_TICKS   = 30,
    parameter int CNT_W        = 8
) (
    input  logic                clk10,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] light,
    output logic [N_FLOORS-1:0] floor,
    output logic                mv_up,
    output logic                mv_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] clr
);

    localparam logic [CNT_W-1:0]    c_TRAVEL_TERM = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0]    c_DOOR_TERM   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [N_FLOORS-1:0] c_FLOOR_GND   = N_FLOORS'(1);

    logic [1:0]          r_state, w_state_nxt;
    logic [N_FLOORS-1:0] r_floor, w_floor_nxt;
    logic [N_FLOORS-1:0] r_clr,   w_clr_nxt;
    logic                r_dir,   w_dir_nxt;

    logic                w_tmr_clear, w_tmr_en, w_tmr_hit, w_tmr_done;
    logic [CNT_W-1:0]    w_tmr_term;

    logic                w_moving, w_arrive, w_decide;
    logic [N_FLOORS-1:0] w_eval_floor, w_below_mask, w_above_mask;
    logic                w_here, w_above, w_below, w_go_up, w_go_down;

    // Timer enable/terminal depend only on the current state, which keeps the
    // timer-done path free of any dependency on the next-state logic.
    assign w_moving   = (r_state == c_ST_MOVE_UP) || (r_state == c_ST_MOVE_DOWN);
    assign w_tmr_en   = w_moving || (r_state == c_ST_DOOR);
    assign w_tmr_term = (r_state == c_ST_DOOR) ? c_DOOR_TERM : c_TRAVEL_TERM;
    assign w_tmr_done = w_tmr_en && w_tmr_hit;
    assign w_arrive   = w_moving && w_tmr_done;

    // On arrival the decision is made against the floor being entered, so
    // consecutive hops chain without an idle cycle.
    always_comb begin
        w_eval_floor = r_floor;
        if (w_arrive && (r_state == c_ST_MOVE_UP)) begin
            w_eval_floor = r_floor << 1;
        end else if (w_arrive) begin
            w_eval_floor = r_floor >> 1;
        end
    end

    // One-hot minus one yields every bit below the car; the complement of
    // (floor | below) leaves every bit above it.
    assign w_below_mask = w_eval_floor - N_FLOORS'(1);
    assign w_above_mask = ~(w_eval_floor | w_below_mask);
    assign w_here       = |(light & w_eval_floor);
    assign w_below      = |(light & w_below_mask);
    assign w_above      = |(light & w_above_mask);

    // SCAN preference: keep going the remembered way while calls remain there.
    assign w_go_up   = w_above && ((r_dir == c_DIR_UP)   || !w_below);
    assign w_go_down = w_below && ((r_dir == c_DIR_DOWN) || !w_above);

    assign w_decide  = (r_state == c_ST_IDLE) || w_arrive;

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = w_eval_floor;
        w_dir_nxt   = r_dir;
        w_clr_nxt   = '0;
        w_tmr_clear = 1'b0;

        if (w_decide) begin
            w_tmr_clear = 1'b1;
            if (w_here) begin
                w_state_nxt = c_ST_DOOR;
                w_clr_nxt   = w_eval_floor;
            end else if (w_go_up) begin
                w_state_nxt = c_ST_MOVE_UP;
                w_dir_nxt   = c_DIR_UP;
            end else if (w_go_down) begin
                w_state_nxt = c_ST_MOVE_DOWN;
                w_dir_nxt   = c_DIR_DOWN;
            end else begin
                w_state_nxt = c_ST_IDLE;
            end
        end else if (r_state == c_ST_DOOR) begin
            // The lamp latch clears one cycle after a clr pulse, so 'here'
            // is only trusted when no pulse is in flight.
            if (w_here && (r_clr == '0)) begin
                w_clr_nxt   = r_floor;
                w_tmr_clear = 1'b1;
            end else if (w_tmr_done) begin
                w_state_nxt = c_ST_IDLE;
                w_tmr_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk10) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_floor <= c_FLOOR_GND;
            r_clr   <= '0;
            r_dir   <= c_DIR_UP;
        end else begin
            r_state <= w_state_nxt;
            r_floor <= w_floor_nxt;
            r_clr   <= w_clr_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    elevator_car_ctrl_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk10  (clk10),
        .rst    (rst),
        .clear  (w_tmr_clear),
        .enable (w_tmr_en),
        .term   (w_tmr_term),
        .done   (w_tmr_hit)
    );

    assign floor     = r_floor;
    assign mv_up     = (r_state == c_ST_MOVE_UP);
    assign mv_down   = (r_state == c_ST_MOVE_DOWN);
    assign door_open = (r_state == c_ST_DOOR);
    assign clr       = r_clr;

endmodule
`default_nettype wire
